// File: rtl/stack_pkg.sv
// Shared encodings for the stack arbiter: op codes, FSM states, stack depth.
package stack_pkg;

    localparam int unsigned STACK_DEPTH = 8;
    localparam int unsigned OP_W        = 2;
    localparam int unsigned ST_W        = 3;

    localparam logic [OP_W-1:0] OP_NOP   = 2'd0;
    localparam logic [OP_W-1:0] OP_CLEAR = 2'd1;
    localparam logic [OP_W-1:0] OP_PUSH  = 2'd2;
    localparam logic [OP_W-1:0] OP_POP   = 2'd3;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_CHECK = 3'd1;
    localparam logic [ST_W-1:0] ST_ISSUE = 3'd2;
    localparam logic [ST_W-1:0] ST_WAIT  = 3'd3;
    localparam logic [ST_W-1:0] ST_RESP  = 3'd4;

    // Push into a full stack or pop from an empty one never reaches the stack.
    function automatic logic op_rejected(input logic [OP_W-1:0] o,
                                         input logic full,
                                         input logic empty);
        return ((o == OP_PUSH) && full) || ((o == OP_POP) && empty);
    endfunction

endpackage

// File: rtl/stack_arbiter_rr_pick.sv
// Combinational round-robin pick: first asserted request after last_grant, wrapping.
module rr_pick #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [GW-1:0]   i_last_grant,
    output logic [GW-1:0]   o_grant_c,
    output logic            o_any_c
);

    logic        w_found;
    int unsigned w_idx;

    always_comb begin
        o_grant_c = '0;
        w_found   = 1'b0;
        w_idx     = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            w_idx = (32'(i_last_grant) + i) % NREQ;
            if (!w_found && i_req[w_idx[GW-1:0]]) begin
                w_found   = 1'b1;
                o_grant_c = w_idx[GW-1:0];
            end
        end
    end

    assign o_any_c = |i_req;

endmodule

// File: rtl/stack_arbiter.sv
// Round-robin sequencer sharing one stack among NREQ requesters; rejects illegal ops
// locally and waits out the stack's one-cycle flag/data latency before acking.
module stack_arbiter
    import stack_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned DW   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] op,
    input  logic [DW*NREQ-1:0] wdata,
    output logic [NREQ-1:0]   ack,
    output logic [DW-1:0]     rdata,
    output logic              err,
    output logic [1:0]        stk_cmd,
    output logic [DW-1:0]     stk_data_in,
    input  logic [DW-1:0]     stk_data_out,
    input  logic              stk_full,
    input  logic              stk_empty,
    input  logic              stk_error
);

    localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [ST_W-1:0] r_state,      w_state_nxt;
    logic [GW-1:0]   r_grant,      w_grant_nxt;
    logic [GW-1:0]   r_last_grant, w_last_grant_nxt;
    logic [OP_W-1:0] r_op,         w_op_nxt;
    logic [DW-1:0]   r_wdata,      w_wdata_nxt;
    logic            r_reject,     w_reject_nxt;
    logic            r_issued,     w_issued_nxt;
    logic [NREQ-1:0] r_ack,        w_ack_nxt;
    logic [DW-1:0]   r_rdata,      w_rdata_nxt;
    logic            r_err,        w_err_nxt;
    logic [OP_W-1:0] r_stk_cmd,    w_stk_cmd_nxt;
    logic [DW-1:0]   r_stk_din,    w_stk_din_nxt;

    logic [GW-1:0]   w_pick;
    logic            w_any;
    logic [OP_W-1:0] w_sel_op;
    logic [DW-1:0]   w_sel_wdata;

    rr_pick #(.NREQ(NREQ), .GW(GW)) u_rr_pick (
        .i_req        (req),
        .i_last_grant (r_last_grant),
        .o_grant_c    (w_pick),
        .o_any_c      (w_any)
    );

    // Mux out the winning requester's op and push data.
    always_comb begin
        w_sel_op    = OP_NOP;
        w_sel_wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_pick == GW'(i)) begin
                w_sel_op    = op[2*i +: 2];
                w_sel_wdata = wdata[DW*i +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= GW'(NREQ - 1);
            r_op         <= OP_NOP;
            r_wdata      <= '0;
            r_reject     <= 1'b0;
            r_issued     <= 1'b0;
            r_ack        <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_stk_cmd    <= OP_NOP;
            r_stk_din    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_op         <= w_op_nxt;
            r_wdata      <= w_wdata_nxt;
            r_reject     <= w_reject_nxt;
            r_issued     <= w_issued_nxt;
            r_ack        <= w_ack_nxt;
            r_rdata      <= w_rdata_nxt;
            r_err        <= w_err_nxt;
            r_stk_cmd    <= w_stk_cmd_nxt;
            r_stk_din    <= w_stk_din_nxt;
        end
    end

    // Next state and registered outputs; the stack command is raised only while in ISSUE.
    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        w_op_nxt         = r_op;
        w_wdata_nxt      = r_wdata;
        w_reject_nxt     = r_reject;
        w_issued_nxt     = r_issued;
        w_ack_nxt        = '0;
        w_rdata_nxt      = r_rdata;
        w_err_nxt        = r_err;
        w_stk_cmd_nxt    = OP_NOP;
        w_stk_din_nxt    = r_stk_din;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_grant_nxt      = w_pick;
                    w_last_grant_nxt = w_pick;
                    w_op_nxt         = w_sel_op;
                    w_wdata_nxt      = w_sel_wdata;
                    w_state_nxt      = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_reject_nxt = 1'b0;
                w_issued_nxt = 1'b0;
                if (r_op == OP_NOP) begin
                    w_state_nxt = ST_RESP;
                end else if (op_rejected(r_op, stk_full, stk_empty)) begin
                    w_reject_nxt = 1'b1;
                    w_state_nxt  = ST_RESP;
                end else begin
                    w_issued_nxt  = 1'b1;
                    w_stk_cmd_nxt = r_op;
                    w_stk_din_nxt = r_wdata;
                    w_state_nxt   = ST_ISSUE;
                end
            end
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  w_state_nxt = ST_RESP;
            ST_RESP: begin
                w_ack_nxt = NREQ'(1) << r_grant;
                if (r_op == OP_POP) begin
                    w_rdata_nxt = stk_data_out;
                end
                w_err_nxt   = r_issued ? stk_error : r_reject;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign ack         = r_ack;
    assign rdata       = r_rdata;
    assign err         = r_err;
    assign stk_cmd     = r_stk_cmd;
    assign stk_data_in = r_stk_din;

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a behavioural 8-deep stack model attached.
module tb_stack_arbiter;
    import stack_pkg::*;

    localparam int unsigned NREQ = 2;
    localparam int unsigned DW   = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [2*NREQ-1:0] op;
    logic [DW*NREQ-1:0] wdata;
    logic [NREQ-1:0]   ack;
    logic [DW-1:0]     rdata;
    logic              err;
    logic [1:0]        stk_cmd;
    logic [DW-1:0]     stk_data_in;
    logic [DW-1:0]     stk_data_out;
    logic              stk_full;
    logic              stk_empty;
    logic              stk_error;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stack_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .op           (op),
        .wdata        (wdata),
        .ack          (ack),
        .rdata        (rdata),
        .err          (err),
        .stk_cmd      (stk_cmd),
        .stk_data_in  (stk_data_in),
        .stk_data_out (stk_data_out),
        .stk_full     (stk_full),
        .stk_empty    (stk_empty),
        .stk_error    (stk_error)
    );

    // Stack model: registered data/error, flags straight from the pointer.
    logic [DW-1:0] m_mem [STACK_DEPTH];
    int unsigned   m_sp   = 0;
    logic [DW-1:0] m_dout = '0;
    logic          m_err  = 1'b0;

    always @(posedge clk) begin
        case (stk_cmd)
            OP_CLEAR: begin m_sp <= 0; m_err <= 1'b0; end
            OP_PUSH: begin
                if (m_sp == STACK_DEPTH) m_err <= 1'b1;
                else begin m_mem[m_sp] <= stk_data_in; m_sp <= m_sp + 1; m_err <= 1'b0; end
            end
            OP_POP: begin
                if (m_sp == 0) m_err <= 1'b1;
                else begin m_dout <= m_mem[m_sp-1]; m_sp <= m_sp - 1; m_err <= 1'b0; end
            end
            default: ;
        endcase
    end

    assign stk_full     = (m_sp == STACK_DEPTH);
    assign stk_empty    = (m_sp == 0);
    assign stk_data_out = m_dout;
    assign stk_error    = m_err;

    typedef struct {
        logic [1:0] req;
        logic [1:0] op0;
        logic [1:0] op1;
        logic [7:0] w0;
        logic [7:0] w1;
        int         exp_idx;
        int         exp_lat;
        logic       exp_err;
        logic       chk_rd;
        logic [7:0] exp_rd;
        logic [1:0] exp_cmd;
        logic [7:0] exp_din;
        logic       drop;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [1:0] rq, input logic [1:0] o0, input logic [1:0] o1,
                                input logic [7:0] w0, input logic [7:0] w1, input int idx,
                                input int lat, input logic e, input logic crd, input logic [7:0] rd,
                                input logic [1:0] cmd, input logic [7:0] din, input logic drop);
        vec_t v;
        v.req = rq; v.op0 = o0; v.op1 = o1; v.w0 = w0; v.w1 = w1;
        v.exp_idx = idx; v.exp_lat = lat; v.exp_err = e; v.chk_rd = crd; v.exp_rd = rd;
        v.exp_cmd = cmd; v.exp_din = din; v.drop = drop;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one op at #1 after an edge; the next posedge is the IDLE sampling edge (c=0).
    task automatic apply_vec(input vec_t v, input string tag);
        int lat  = -1;
        int ncmd = 0;
        logic [1:0] cmdv = '0;
        logic [7:0] dinv = '0;
        req   = v.req;
        op    = {v.op1, v.op0};
        wdata = {v.w1, v.w0};
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (v.drop) req = '0;
            if (stk_cmd != OP_NOP) begin ncmd++; cmdv = stk_cmd; dinv = stk_data_in; end
            if (ack != '0) begin lat = c; break; end
        end
        req = '0;
        op  = '0;
        chk({tag, "_ack_seen"}, 32'(lat >= 0), 32'd1);
        if (lat >= 0) begin
            chk({tag, "_ack"}, 32'(ack), 32'(1) << v.exp_idx);
            chk({tag, "_lat"}, 32'(lat), 32'(v.exp_lat));
            chk({tag, "_err"}, 32'(err), 32'(v.exp_err));
            chk({tag, "_ncmd"}, 32'(ncmd), (v.exp_cmd == OP_NOP) ? 32'd0 : 32'd1);
            if (v.exp_cmd != OP_NOP) chk({tag, "_cmd"}, 32'(cmdv), 32'(v.exp_cmd));
            if (v.exp_cmd == OP_PUSH) chk({tag, "_din"}, 32'(dinv), 32'(v.exp_din));
            if (v.chk_rd) chk({tag, "_rdata"}, 32'(rdata), 32'(v.exp_rd));
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        op    = '0;
        wdata = '0;

        //         req    op0       op1       w0     w1     idx lat err crd rd     cmd       din    drop
        tbl.push_back(mk(2'b01, OP_PUSH, OP_NOP,  8'hA5, 8'h00, 0, 4, 0, 0, 8'h00, OP_PUSH,  8'hA5, 0));
        tbl.push_back(mk(2'b11, OP_PUSH, OP_PUSH, 8'h10, 8'h20, 1, 4, 0, 0, 8'h00, OP_PUSH,  8'h20, 0));
        tbl.push_back(mk(2'b11, OP_PUSH, OP_PUSH, 8'h10, 8'h20, 0, 4, 0, 0, 8'h00, OP_PUSH,  8'h10, 0));
        tbl.push_back(mk(2'b11, OP_PUSH, OP_PUSH, 8'h10, 8'h20, 1, 4, 0, 0, 8'h00, OP_PUSH,  8'h20, 0));
        tbl.push_back(mk(2'b11, OP_PUSH, OP_PUSH, 8'h10, 8'h20, 0, 4, 0, 0, 8'h00, OP_PUSH,  8'h10, 0));
        tbl.push_back(mk(2'b10, OP_NOP,  OP_CLEAR,8'h00, 8'h00, 1, 4, 0, 0, 8'h00, OP_CLEAR, 8'h00, 0));
        tbl.push_back(mk(2'b10, OP_NOP,  OP_POP,  8'h00, 8'h00, 1, 2, 1, 0, 8'h00, OP_NOP,   8'h00, 0));
        tbl.push_back(mk(2'b01, OP_PUSH, OP_NOP,  8'h11, 8'h00, 0, 4, 0, 0, 8'h00, OP_PUSH,  8'h11, 0));
        tbl.push_back(mk(2'b10, OP_NOP,  OP_PUSH, 8'h00, 8'h22, 1, 4, 0, 0, 8'h00, OP_PUSH,  8'h22, 0));
        tbl.push_back(mk(2'b01, OP_POP,  OP_NOP,  8'h00, 8'h00, 0, 4, 0, 1, 8'h22, OP_POP,   8'h00, 0));
        tbl.push_back(mk(2'b01, OP_NOP,  OP_NOP,  8'h00, 8'h00, 0, 2, 0, 1, 8'h22, OP_NOP,   8'h00, 0));
        for (int j = 0; j < 7; j++)
            tbl.push_back(mk(2'b01, OP_PUSH, OP_NOP, 8'(8'h30 + j), 8'h00, 0, 4, 0, 1, 8'h22,
                             OP_PUSH, 8'(8'h30 + j), 0));
        tbl.push_back(mk(2'b01, OP_PUSH, OP_NOP,  8'h99, 8'h00, 0, 2, 1, 1, 8'h22, OP_NOP,   8'h00, 0));
        tbl.push_back(mk(2'b10, OP_NOP,  OP_CLEAR,8'h00, 8'h00, 1, 4, 0, 0, 8'h00, OP_CLEAR, 8'h00, 0));
        tbl.push_back(mk(2'b01, OP_POP,  OP_NOP,  8'h00, 8'h00, 0, 2, 1, 0, 8'h00, OP_NOP,   8'h00, 0));

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack",   32'(ack),         32'd0);
        chk("rst_rdata", 32'(rdata),       32'd0);
        chk("rst_err",   32'(err),         32'd0);
        chk("rst_cmd",   32'(stk_cmd),     32'd0);
        chk("rst_din",   32'(stk_data_in), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) apply_vec(tbl[i], $sformatf("v%0d", i));

        // Reset while the op sits in WAIT: the push already reached the stack, no ack follows.
        req = 2'b10; op = {OP_PUSH, OP_NOP}; wdata = {8'h77, 8'h00};
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1; req = '0; op = '0;
        @(posedge clk); #1;
        chk("rstmid_ack", 32'(ack),     32'd0);
        chk("rstmid_cmd", 32'(stk_cmd), 32'd0);
        chk("rstmid_sp",  32'(m_sp),    32'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_idle_ack", 32'(ack), 32'd0);
        apply_vec(mk(2'b11, OP_PUSH, OP_PUSH, 8'h40, 8'h41, 0, 4, 0, 0, 8'h00, OP_PUSH, 8'h40, 0), "post_rst");

        // Request dropped right after being sampled still completes and acks.
        apply_vec(mk(2'b10, OP_NOP, OP_PUSH, 8'h00, 8'h55, 1, 4, 0, 0, 8'h00, OP_PUSH, 8'h55, 1), "drop");
        apply_vec(mk(2'b01, OP_POP, OP_NOP, 8'h00, 8'h00, 0, 4, 0, 1, 8'h55, OP_POP, 8'h00, 0), "drop_pop");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
